// File: rtl/muldiv_issue.sv
// RV32M multiply issue block: accepts one M-extension op, drives an external
// pipelined multiplier, and holds the result until writeback takes it.
// Ports: clk, rst (async, active-high); req_* (request handshake, operands,
// funct3, rd tag); mul_* (multiplier operands, start, type code, funct3,
// result, stall); rsp_* (result handshake, data, rd tag, err, cache hit).
// Parameter MUL_DEPTH must match the attached multiplier's DEPTH.
// Optional macro MULDIV_RESULT_CACHE_EN adds a one-entry result cache.
module muldiv_issue #(
  parameter int MUL_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_start,
  output logic [2:0]  mul_op,
  output logic [2:0]  mul_funct3,
  input  logic [31:0] mul_fout,
  input  logic        mul_stall,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        rsp_hit
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Multiplier type codes: bit0 = rs1 signed, bit1 = rs2 signed.
  localparam logic [2:0] OP_SS = 3'b011;
  localparam logic [2:0] OP_SU = 3'b001;
  localparam logic [2:0] OP_UU = 3'b000;

  localparam int CW =
    (MUL_DEPTH < 1) ? 1 : $clog2(MUL_DEPTH + 1);
  localparam logic [CW-1:0] DEP = CW'(MUL_DEPTH);

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [2:0]    f3_q, f3_d;
  logic [2:0]    op_q, op_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    op_sel;

`ifdef MULDIV_RESULT_CACHE_EN
  logic          hit_q, hit_d;
  logic          c_vld_q, c_vld_d;
  logic [31:0]   c_a_q, c_a_d;
  logic [31:0]   c_b_q, c_b_d;
  logic [2:0]    c_f3_q, c_f3_d;
  logic [31:0]   c_res_q, c_res_d;
  logic          c_hit;

  assign c_hit = c_vld_q
              && (c_a_q == req_a)
              && (c_b_q == req_b)
              && (c_f3_q == req_funct3);
`endif

  always_comb begin
    op_sel = OP_SS;
    unique case (req_funct3[1:0])
      2'b10:   op_sel = OP_SU;
      2'b11:   op_sel = OP_UU;
      default: op_sel = OP_SS;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f3_d    = f3_q;
    op_d    = op_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
`ifdef MULDIV_RESULT_CACHE_EN
    hit_d   = hit_q;
    c_vld_d = c_vld_q;
    c_a_d   = c_a_q;
    c_b_d   = c_b_q;
    c_f3_d  = c_f3_q;
    c_res_d = c_res_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rd_d = req_rd;
          if (req_funct3[2]) begin
            // Divide/remainder are not served here.
            data_d  = '0;
            err_d   = 1'b1;
`ifdef MULDIV_RESULT_CACHE_EN
            hit_d   = 1'b0;
`endif
            state_d = HOLD;
          end else begin
            a_d     = req_a;
            b_d     = req_b;
            f3_d    = req_funct3;
            op_d    = op_sel;
            cyc_d   = '0;
            state_d = ISSUE;
`ifdef MULDIV_RESULT_CACHE_EN
            hit_d   = 1'b0;
            if (c_hit) begin
              data_d  = c_res_q;
              err_d   = 1'b0;
              hit_d   = 1'b1;
              state_d = HOLD;
            end
`endif
          end
        end
      end
      ISSUE: begin
        // The multiplier cannot finish in fewer than MUL_DEPTH
        // cycles; a low stall before that is a stale busy flag.
        if (!mul_stall && (cyc_q >= DEP)) begin
          data_d  = mul_fout;
          err_d   = 1'b0;
          state_d = HOLD;
`ifdef MULDIV_RESULT_CACHE_EN
          hit_d   = 1'b0;
          c_vld_d = 1'b1;
          c_a_d   = a_q;
          c_b_d   = b_q;
          c_f3_d  = f3_q;
          c_res_d = mul_fout;
`endif
        end else if (cyc_q != DEP) begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

`ifdef MULDIV_RESULT_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= 1'b0;
      c_vld_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_f3_q  <= '0;
      c_res_q <= '0;
    end else begin
      hit_q   <= hit_d;
      c_vld_q <= c_vld_d;
      c_a_q   <= c_a_d;
      c_b_q   <= c_b_d;
      c_f3_q  <= c_f3_d;
      c_res_q <= c_res_d;
    end
  end

  assign rsp_hit = hit_q;
`else
  assign rsp_hit = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign mul_start  = (state_q == ISSUE);
  assign rsp_valid  = (state_q == HOLD);
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_op     = op_q;
  assign mul_funct3 = f3_q;
  assign rsp_data   = data_q;
  assign rsp_rd     = rd_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed bench for muldiv_issue with a behavioural multiplier model.
module tb_muldiv_issue;

  localparam int MUL_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_start;
  logic [2:0]  mul_op;
  logic [2:0]  mul_funct3;
  logic [31:0] mul_fout;
  logic        mul_stall;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        rsp_hit;

  int nvec = 0;
  int nerr = 0;
  int nstart = 0;
  logic [2:0]  last_op = '0;
  logic [31:0] last_a = '0;

  muldiv_issue #(.MUL_DEPTH(MUL_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_a(req_a),
    .req_b(req_b), .req_rd(req_rd),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_op(mul_op),
    .mul_funct3(mul_funct3), .mul_fout(mul_fout),
    .mul_stall(mul_stall),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_err(rsp_err), .rsp_hit(rsp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: busy for MUL_DEPTH+1 cycles of start, then valid.
  int unsigned m_cnt;
  logic signed [32:0] ea, eb;
  logic signed [63:0] prod;

  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 0;
    else if (!mul_start) m_cnt <= 0;
    else m_cnt <= m_cnt + 1;
  end

  assign mul_stall = mul_start && (m_cnt < MUL_DEPTH + 1);

  always_comb begin
    ea = $signed({mul_op[0] & mul_a[31], mul_a});
    eb = $signed({mul_op[1] & mul_b[31], mul_b});
    prod = ea * eb;
  end

  assign mul_fout = (!mul_start || mul_stall) ? 32'hDEADBEEF :
                    (mul_funct3 == 3'b000) ? prod[31:0] : prod[63:32];

  always @(posedge clk) begin
    if (mul_start) begin
      nstart  <= nstart + 1;
      last_op <= mul_op;
      last_a  <= mul_a;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Issue one op from IDLE and wait (bounded) for rsp_valid.
  // lat counts edges from the accept edge (accept edge = 1).
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic rdy, output int lat,
                       output logic [31:0] d, output logic [4:0] r,
                       output logic e, output logic h, output logic ms);
    req_valid = 1'b1;
    req_funct3 = f3;
    req_a = a;
    req_b = b;
    req_rd = rd;
    rsp_ready = rdy;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 32'hA5A5A5A5;
    req_b = 32'h5A5A5A5A;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    d = rsp_data;
    r = rsp_rd;
    e = rsp_err;
    h = rsp_hit;
    ms = mul_start;
    if (rdy) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    req_funct3 = '0;
    req_a = '0;
    req_b = '0;
    req_rd = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (mul_start !== 1'b0) begin nerr++; $display("FAIL rst_mul_start got %b exp 0", mul_start); end
    nvec++; if (mul_a !== 32'h0) begin nerr++; $display("FAIL rst_mul_a got %h exp 0", mul_a); end
    nvec++; if (mul_b !== 32'h0) begin nerr++; $display("FAIL rst_mul_b got %h exp 0", mul_b); end
    nvec++; if (mul_op !== 3'h0) begin nerr++; $display("FAIL rst_mul_op got %h exp 0", mul_op); end
    nvec++; if (mul_funct3 !== 3'h0) begin nerr++; $display("FAIL rst_mul_funct3 got %h exp 0", mul_funct3); end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    nvec++; if (rsp_data !== 32'h0) begin nerr++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
    nvec++; if (rsp_rd !== 5'h0) begin nerr++; $display("FAIL rst_rsp_rd got %h exp 0", rsp_rd); end
    nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    nvec++; if (rsp_hit !== 1'b0) begin nerr++; $display("FAIL rst_rsp_hit got %b exp 0", rsp_hit); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int lat;
    logic [31:0] d;
    logic [4:0] r;
    logic e, h, ms;
    do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1, lat, d, r, e, h, ms);
    nvec++; if (d !== 32'hFFFFFFEB) begin nerr++; $display("FAIL mul_data got %h exp ffffffeb", d); end
    nvec++; if (e !== 1'b0) begin nerr++; $display("FAIL mul_err got %b exp 0", e); end
    nvec++; if (r !== 5'd5) begin nerr++; $display("FAIL mul_rd got %0d exp 5", r); end
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL mul_latency got %0d exp 5", lat); end
    nvec++; if (h !== 1'b0) begin nerr++; $display("FAIL mul_hit got %b exp 0", h); end
    nvec++; if (ms !== 1'b0) begin nerr++; $display("FAIL mul_start_in_hold got %b exp 0", ms); end
    nvec++; if (last_op !== 3'b011) begin nerr++; $display("FAIL mul_op_ss got %b exp 011", last_op); end
    nvec++; if (last_a !== 32'd7) begin nerr++; $display("FAIL mul_a_seen got %h exp 7", last_a); end
    nvec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin nerr++; $display("FAIL mul_back_idle got rdy=%b vld=%b exp rdy=1 vld=0", req_ready, rsp_valid); end
  endtask

  task automatic test_mulh;
    logic [2:0]  f3 [3];
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] ex [3];
    logic [2:0]  eo [3];
    int lat;
    logic [31:0] d;
    logic [4:0] r;
    logic e, h, ms;
    f3[0] = 3'b011; va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; ex[0] = 32'hFFFFFFFE; eo[0] = 3'b000;
    f3[1] = 3'b010; va[1] = 32'hFFFFFFFF; vb[1] = 32'd2;        ex[1] = 32'hFFFFFFFF; eo[1] = 3'b001;
    f3[2] = 3'b001; va[2] = 32'hFFFFFFFE; vb[2] = 32'd3;        ex[2] = 32'hFFFFFFFF; eo[2] = 3'b011;
    for (int i = 0; i < 3; i++) begin
      do_op(f3[i], va[i], vb[i], 5'(i + 1), 1'b1, lat, d, r, e, h, ms);
      nvec++; if (d !== ex[i]) begin nerr++; $display("FAIL mulh%0d_data got %h exp %h", i, d, ex[i]); end
      nvec++; if (last_op !== eo[i]) begin nerr++; $display("FAIL mulh%0d_op got %b exp %b", i, last_op, eo[i]); end
      nvec++; if (lat !== 5 || e !== 1'b0) begin nerr++; $display("FAIL mulh%0d_lat_err got %0d/%b exp 5/0", i, lat, e); end
    end
  endtask

  task automatic test_err;
    int lat;
    int s0;
    logic [31:0] d;
    logic [4:0] r;
    logic e, h, ms;
    s0 = nstart;
    do_op(3'b100, 32'd1, 32'd1, 5'd9, 1'b1, lat, d, r, e, h, ms);
    nvec++; if (nstart !== s0) begin nerr++; $display("FAIL err_no_start got %0d exp %0d", nstart, s0); end
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL err_latency got %0d exp 1", lat); end
    nvec++; if (e !== 1'b1) begin nerr++; $display("FAIL err_flag got %b exp 1", e); end
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL err_data got %h exp 0", d); end
    nvec++; if (r !== 5'd9) begin nerr++; $display("FAIL err_rd got %0d exp 9", r); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] d;
    logic [4:0] r;
    logic e, h, ms;
    do_op(3'b000, 32'h00010000, 32'h00010001, 5'd12, 1'b0, lat, d, r, e, h, ms);
    nvec++; if (d !== 32'h00010000 || lat !== 5) begin nerr++; $display("FAIL bp_first got %h/%0d exp 00010000/5", d, lat); end
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_funct3 = 3'(i % 5);
      req_a = 32'(i);
      req_b = 32'(i * 3);
      req_rd = 5'(i);
      @(posedge clk); #1;
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h00010000 || rsp_rd !== 5'd12 ||
          rsp_err !== 1'b0 || req_ready !== 1'b0 || mul_start !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold%0d got vld=%b d=%h rd=%0d err=%b rdy=%b st=%b exp 1/00010000/12/0/0/0",
                 i, rsp_valid, rsp_data, rsp_rd, rsp_err, req_ready, mul_start);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    nvec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin nerr++; $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
    do_op(3'b000, 32'd100, 32'd200, 5'd13, 1'b1, lat, d, r, e, h, ms);
    nvec++; if (d !== 32'h00004E20) begin nerr++; $display("FAIL b2b_data got %h exp 00004e20", d); end
    nvec++; if (lat !== 5 || r !== 5'd13) begin nerr++; $display("FAIL b2b_lat_rd got %0d/%0d exp 5/13", lat, r); end
  endtask

  task automatic test_reset_mid_issue;
    int lat;
    logic [31:0] d;
    logic [4:0] r;
    logic e, h, ms;
    req_valid = 1'b1;
    req_funct3 = 3'b000;
    req_a = 32'd9;
    req_b = 32'd9;
    req_rd = 5'd3;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nvec++; if (mul_start !== 1'b1) begin nerr++; $display("FAIL rmi_in_issue got %b exp 1", mul_start); end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    nvec++; if (mul_start !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0) begin nerr++; $display("FAIL rmi_mul got st=%b a=%h b=%h exp 0/0/0", mul_start, mul_a, mul_b); end
    nvec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin nerr++; $display("FAIL rmi_hs got rdy=%b vld=%b exp 1/0", req_ready, rsp_valid); end
    nvec++; if (rsp_data !== 32'h0 || rsp_rd !== 5'h0) begin nerr++; $display("FAIL rmi_rsp got d=%h rd=%0d exp 0/0", rsp_data, rsp_rd); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(3'b000, 32'd3, 32'd4, 5'd7, 1'b1, lat, d, r, e, h, ms);
    nvec++; if (d !== 32'd12) begin nerr++; $display("FAIL rmi_mul34 got %h exp 0000000c", d); end
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL rmi_latency got %0d exp 5", lat); end
  endtask

  task automatic test_cache;
    int lat;
    int s1;
    logic [31:0] d;
    logic [4:0] r;
    logic e, h, ms;
    do_op(3'b001, 32'd5, 32'd6, 5'd20, 1'b1, lat, d, r, e, h, ms);
    nvec++; if (d !== 32'h0 || lat !== 5 || h !== 1'b0) begin nerr++; $display("FAIL c1 got %h/%0d/%b exp 0/5/0", d, lat, h); end
    s1 = nstart;
    do_op(3'b001, 32'd5, 32'd6, 5'd21, 1'b1, lat, d, r, e, h, ms);
`ifdef MULDIV_RESULT_CACHE_EN
    nvec++; if (lat !== 1 || h !== 1'b1) begin nerr++; $display("FAIL c2_hit got %0d/%b exp 1/1", lat, h); end
    nvec++; if (nstart !== s1) begin nerr++; $display("FAIL c2_no_start got %0d exp %0d", nstart, s1); end
`else
    nvec++; if (lat !== 5 || h !== 1'b0) begin nerr++; $display("FAIL c2_nocache got %0d/%b exp 5/0", lat, h); end
    nvec++; if (nstart === s1) begin nerr++; $display("FAIL c2_start got %0d exp >%0d", nstart, s1); end
`endif
    nvec++; if (d !== 32'h0 || r !== 5'd21) begin nerr++; $display("FAIL c2_data got %h/%0d exp 0/21", d, r); end
    do_op(3'b001, 32'd5, 32'd7, 5'd22, 1'b1, lat, d, r, e, h, ms);
    nvec++; if (lat !== 5 || h !== 1'b0) begin nerr++; $display("FAIL c3_miss got %0d/%b exp 5/0", lat, h); end
    do_op(3'b000, 32'd5, 32'd7, 5'd23, 1'b1, lat, d, r, e, h, ms);
    nvec++; if (d !== 32'd35 || lat !== 5) begin nerr++; $display("FAIL c4_f3_miss got %h/%0d exp 00000023/5", d, lat); end
    do_op(3'b000, 32'd5, 32'd7, 5'd24, 1'b1, lat, d, r, e, h, ms);
`ifdef MULDIV_RESULT_CACHE_EN
    nvec++; if (d !== 32'd35 || lat !== 1 || h !== 1'b1) begin nerr++; $display("FAIL c5_hit got %h/%0d/%b exp 00000023/1/1", d, lat, h); end
`else
    nvec++; if (d !== 32'd35 || lat !== 5 || h !== 1'b0) begin nerr++; $display("FAIL c5_nocache got %h/%0d/%b exp 00000023/5/0", d, lat, h); end
`endif
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_err();
    test_back_to_back();
    test_reset_mid_issue();
    test_cache();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_issue.md
MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 Parameter: MUL_DEPTH, default 2, pipeline depth of the attached multiplier; must equal that multiplier's DEPTH.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  execute stage presents an M-extension op.
REQ-005 req_ready  output  1  block can accept an op this cycle.
REQ-006 req_funct3  input  3  RV32M funct3.
REQ-007 req_a, req_b  input  32 each  rs1 and rs2 operand values.
REQ-008 req_rd  input  5  destination register tag.
REQ-009 mul_a, mul_b  output  32 each  registered operands to the multiplier.
REQ-010 mul_start  output  1  multiplier start, held until the result returns.
REQ-011 mul_op  output  3  multiplier type code from rv32imc_types; [1:0] selects signedness.
REQ-012 mul_funct3  output  3  registered funct3 to the multiplier output mux.
REQ-013 mul_fout  input  32  multiplier result.
REQ-014 mul_stall  input  1  multiplier busy; low while mul_start is high means mul_fout is valid.
REQ-015 rsp_valid  output  1  result available to writeback.
REQ-016 rsp_ready  input  1  writeback accepts the result.
REQ-017 rsp_data  output  32  result value.
REQ-018 rsp_rd  output  5  tag of the result.
REQ-019 rsp_err  output  1  op was not a multiply (funct3[2]=1).
REQ-020 rsp_hit  output  1  result was served from the result cache.

Function
REQ-021 FSM states: IDLE, ISSUE, HOLD; req_ready=1 only in IDLE.
REQ-022 IDLE, req_valid=1, funct3[2]=0: latch a, b, funct3, rd; next state ISSUE.
REQ-023 IDLE, req_valid=1, funct3[2]=1: latch rd; rsp_data<=0, rsp_err<=1; next state HOLD; mul_start is never asserted.
REQ-024 ISSUE: mul_start=1, with mul_a, mul_b, mul_op and mul_funct3 stable from the latched registers.
REQ-025 mul_op mapping: MUL/MULH -> signed x signed, MULHSU -> signed x unsigned, MULHU -> unsigned x unsigned.
REQ-026 ISSUE with mul_stall=0: capture mul_fout into rsp_data and set rsp_err=0; next state HOLD.
REQ-027 mul_start is 0 in every cycle outside ISSUE, so the multiplier's busy flag clears before the next issue.
REQ-028 HOLD: rsp_valid=1; rsp_data, rsp_rd, rsp_err and rsp_hit are stable until the handshake.
REQ-029 HOLD with rsp_ready=1: next state IDLE; the next request is accepted no earlier than the following cycle.
REQ-030 Latency with rsp_ready held high: rsp_valid rises MUL_DEPTH+3 cycles after the accept edge (5 cycles for default).
REQ-031 rsp_valid is never high in IDLE or ISSUE.
REQ-032 rsp_ready is ignored outside HOLD.
REQ-033 req_* inputs are ignored outside IDLE.

Reset
REQ-034 Asserting rst forces state IDLE immediately, in any state, including mid-ISSUE.
REQ-035 Reset values: req_ready=1 once rst deasserts; mul_start=0; mul_a=0; mul_b=0; mul_op=0; mul_funct3=0; rsp_valid=0; rsp_data=0; rsp_rd=0; rsp_err=0; rsp_hit=0.
REQ-036 Reset clears the cache valid bit; the multiplier shares rst, so no flush is required.

Configuration
REQ-037 Macro MULDIV_RESULT_CACHE_EN defined: store {a, b, funct3, result} of the last completed multiply.
REQ-038 Cache hit: IDLE accept with a valid entry whose a, b and funct3 all match goes directly to HOLD with the cached result and rsp_hit=1; mul_start is not asserted; rsp_valid rises 1 cycle after accept.
REQ-039 Cache update: the entry is written at every ISSUE->HOLD transition; err ops never update it.
REQ-040 Macro undefined: no cache storage; every multiply goes through ISSUE; rsp_hit is tied to 0.

Verification
REQ-041 MUL: a=7, b=-3 (0xFFFFFFFD), rsp_ready=1 -> rsp_data=0xFFFFFFEB, rsp_err=0, rsp_valid 5 cycles after accept.
REQ-042 MULHU: a=b=0xFFFFFFFF -> rsp_data=0xFFFFFFFE; MULHSU: a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-043 DIV op (funct3=100), rd=9 -> no mul_start pulse; rsp_valid the next cycle with rsp_err=1, rsp_data=0, rsp_rd=9.
REQ-044 Backpressure: rsp_ready=0 for 10 cycles in HOLD -> outputs stable, req_ready=0; release -> IDLE the next cycle, and a back-to-back MUL completes correctly.
REQ-045 rst asserted 2 cycles into ISSUE -> outputs are at reset values immediately; a new MUL 3*4 returns 12 with correct latency.
REQ-046 Cache enabled: MULH 5,6 twice in succession -> second response has rsp_hit=1, arrives 1 cycle after accept, and mul_start stays low; a third op with b=7 misses.
